// File: rtl/display_scheduler_pkg.sv
// Shared types and helpers for the two-source multiplexed 7-segment scheduler.
package display_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } sched_state_t;

    localparam int          N_DIGITS   = 8;
    localparam logic [7:0]  ANODES_OFF = 8'hFF;

    // One-hot grant vector for a scheduler state; IDLE owns nothing.
    function automatic logic [1:0] owner_grant(input sched_state_t s);
        logic [1:0] g;
        g = 2'b00;
        case (s)
            OWN0:    g = 2'b01;
            OWN1:    g = 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

    // True when digit k is a leading zero: every nibble from k upward is zero.
    // Digit 0 is always shown so a zero word still reads "0".
    function automatic logic digit_blank(input logic [31:0] word, input logic [2:0] k);
        logic [31:0] upper;
        upper = word >> {k, 2'b00};
        return (k != 3'd0) && (upper == 32'd0);
    endfunction

endpackage

// File: rtl/display_scheduler_if.sv
// Requester/display bundle between the two sources and the scheduler.
interface display_scheduler_if;
    logic [1:0]  req;
    logic [31:0] data0;
    logic [31:0] data1;
    logic        lz_blank;
    logic [1:0]  grant;
    logic [3:0]  digit_value;
    logic [7:0]  anodes;
    logic        frame_done;

    // Master drives requests and words, observes the display side.
    modport master (
        output req, data0, data1, lz_blank,
        input  grant, digit_value, anodes, frame_done
    );

    // Slave is the scheduler itself.
    modport slave (
        input  req, data0, data1, lz_blank,
        output grant, digit_value, anodes, frame_done
    );
endinterface

// File: rtl/display_scheduler_scan_timebase.sv
// Digit scan timebase: prescaler, 3-bit digit index and frame-boundary pulse.
module scan_timebase #(
    parameter int PRESCALE = 100_000
) (
    input  logic       clock_i,
    input  logic       reset_ni,
    output logic       tick_o,
    output logic       wrap_o,
    output logic [2:0] idx_o,
    output logic       frame_done_o
);

    localparam int             PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] prescaler_q, prescaler_d;
    logic [2:0]    idx_q, idx_d;
    logic          frame_done_q;

    assign tick_o       = (prescaler_q == PRE_LAST);
    assign wrap_o       = tick_o && (idx_q == 3'd7);
    assign idx_o        = idx_q;
    assign frame_done_o = frame_done_q;

    // Next prescaler count and digit index; index advances only on a tick.
    always_comb begin
        prescaler_d = tick_o ? '0 : prescaler_q + 1'b1;
        idx_d       = tick_o ? idx_q + 3'd1 : idx_q;
    end

    // Timebase registers; frame_done is high for the first cycle of each new frame.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            prescaler_q  <= '0;
            idx_q        <= 3'd0;
            frame_done_q <= 1'b0;
        end else begin
            prescaler_q  <= prescaler_d;
            idx_q        <= idx_d;
            frame_done_q <= wrap_o;
        end
    end

endmodule

// File: rtl/display_scheduler.sv
// Two-requester 8-digit display scheduler: round-robin ownership with a minimum
// hold, once-per-frame snapshot of the owner's word, leading-zero blanking.
//
//   state | meaning
//   IDLE  | nobody owns the display, all anodes off
//   OWN0  | source 0 owns the display for the current frame
//   OWN1  | source 1 owns the display for the current frame
module display_scheduler
    import display_sched_pkg::*;
#(
    parameter int PRESCALE    = 100_000,
    parameter int HOLD_FRAMES = 4
) (
    input  logic                clock_i,
    input  logic                reset_ni,
    display_scheduler_if.slave  disp_io
);

    localparam int             HW        = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_FRAMES - 1);

    logic        tick;
    logic        wrap;
    logic [2:0]  idx;
    logic [2:0]  idx_next;
    logic        frame_done;

    sched_state_t  state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          last_owner_q, last_owner_d;
    logic [1:0]    grant_q;
    logic [31:0]   buf_q, buf_d;
    logic [7:0]    anodes_q, anodes_d;
    logic [3:0]    digit_q, digit_d;

    scan_timebase #(
        .PRESCALE (PRESCALE)
    ) u_timebase (
        .clock_i      (clock_i),
        .reset_ni     (reset_ni),
        .tick_o       (tick),
        .wrap_o       (wrap),
        .idx_o        (idx),
        .frame_done_o (frame_done)
    );

    assign idx_next = idx + 3'd1;

    // Ownership decision, taken only at the frame boundary. A release is honoured
    // before any contention/hold check so a departing owner never pins the display.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        last_owner_d = last_owner_q;
        if (wrap) begin
            case (state_q)
                IDLE: begin
                    if (disp_io.req == 2'b11)
                        state_d = last_owner_q ? OWN0 : OWN1;
                    else if (disp_io.req[0])
                        state_d = OWN0;
                    else if (disp_io.req[1])
                        state_d = OWN1;
                end
                OWN0: begin
                    if (!disp_io.req[0])
                        state_d = disp_io.req[1] ? OWN1 : IDLE;
                    else if (disp_io.req[1] && (hold_q == HOLD_LAST))
                        state_d = OWN1;
                    else if (hold_q != HOLD_LAST)
                        hold_d = hold_q + 1'b1;
                end
                OWN1: begin
                    if (!disp_io.req[1])
                        state_d = disp_io.req[0] ? OWN0 : IDLE;
                    else if (disp_io.req[0] && (hold_q == HOLD_LAST))
                        state_d = OWN0;
                    else if (hold_q != HOLD_LAST)
                        hold_d = hold_q + 1'b1;
                end
                default: state_d = IDLE;
            endcase
            if ((state_d != state_q) && (state_d != IDLE)) begin
                hold_d       = '0;
                last_owner_d = (state_d == OWN1);
            end
        end
    end

    // Scheduler registers; grant is registered alongside the state it decodes.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            last_owner_q <= 1'b1;
            grant_q      <= 2'b00;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            last_owner_q <= last_owner_d;
            grant_q      <= owner_grant(state_d);
        end
    end

    // Frame snapshot and the digit that becomes visible on this tick. Outputs are
    // computed from next-cycle index/owner/buffer so they move on the same edge as idx.
    always_comb begin
        buf_d    = buf_q;
        anodes_d = anodes_q;
        digit_d  = digit_q;
        if (wrap) begin
            case (state_d)
                OWN0:    buf_d = disp_io.data0;
                OWN1:    buf_d = disp_io.data1;
                default: buf_d = 32'd0;
            endcase
        end
        if (tick) begin
            if ((state_d == IDLE) || (disp_io.lz_blank && digit_blank(buf_d, idx_next))) begin
                anodes_d = ANODES_OFF;
                digit_d  = 4'd0;
            end else begin
                anodes_d = ~(8'b1 << idx_next);
                digit_d  = buf_d[{idx_next, 2'b00} +: 4];
            end
        end
    end

    // Frame buffer and display output registers.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            buf_q    <= 32'd0;
            anodes_q <= ANODES_OFF;
            digit_q  <= 4'd0;
        end else begin
            buf_q    <= buf_d;
            anodes_q <= anodes_d;
            digit_q  <= digit_d;
        end
    end

    assign disp_io.grant       = grant_q;
    assign disp_io.anodes      = anodes_q;
    assign disp_io.digit_value = digit_q;
    assign disp_io.frame_done  = frame_done;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with PRESCALE=2, HOLD_FRAMES=2 (16-cycle frame).
module tb_display_scheduler;

    logic clock_i  = 1'b0;
    logic reset_ni = 1'b0;

    always #5 clock_i = ~clock_i;

    display_scheduler_if dif();

    display_scheduler #(
        .PRESCALE    (2),
        .HOLD_FRAMES (2)
    ) dut (
        .clock_i  (clock_i),
        .reset_ni (reset_ni),
        .disp_io  (dif)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] an_dig  [8];
    logic [3:0] v_dig   [8];
    logic [7:0] an_lz   [8];
    logic [3:0] v_lz    [8];
    logic [7:0] an_zero [8];
    logic [3:0] v_zero  [8];
    logic [1:0] exp_g   [5];
    logic [3:0] exp_d0  [5];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next frame_done cycle; grant must not move before it.
    task automatic wait_fd(input string tag, input logic [1:0] cur_grant, output int n);
        n = 0;
        do begin
            @(negedge clock_i);
            n++;
            if (!dif.frame_done)
                check({tag, " grant mid-frame"}, 32'(dif.grant), 32'(cur_grant));
        end while (!dif.frame_done && n < 40);
        check({tag, " frame_done seen"}, 32'(dif.frame_done), 32'd1);
    endtask

    // Called in the first cycle of a frame; checks all 16 cycles and lands on the next frame_done.
    task automatic check_frame(input string tag, input logic [7:0] ea [8], input logic [3:0] ev [8],
                               input int change_k, input logic [31:0] new_data0);
        for (int k = 0; k < 8; k++) begin
            for (int r = 0; r < 2; r++) begin
                check($sformatf("%s anodes d%0d", tag, k), 32'(dif.anodes), 32'(ea[k]));
                check($sformatf("%s value d%0d", tag, k), 32'(dif.digit_value), 32'(ev[k]));
                if (k == change_k && r == 0)
                    dif.data0 = new_data0;
                @(negedge clock_i);
            end
        end
        check({tag, " next frame_done"}, 32'(dif.frame_done), 32'd1);
    endtask

    initial begin
        int n;
        logic [1:0] prev;

        an_dig  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
        v_dig   = '{4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
        an_lz   = '{8'hFE, 8'hFD, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        v_lz    = '{4'h5, 4'hA, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        an_zero = '{8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        v_zero  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        exp_g   = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01};
        exp_d0  = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h1};

        dif.req      = 2'b00;
        dif.data0    = 32'd0;
        dif.data1    = 32'd0;
        dif.lz_blank = 1'b0;

        // Held in reset with the clock running.
        repeat (3) @(negedge clock_i);
        check("reset anodes", 32'(dif.anodes), 32'hFF);
        check("reset grant", 32'(dif.grant), 32'd0);
        check("reset value", 32'(dif.digit_value), 32'd0);
        check("reset frame_done", 32'(dif.frame_done), 32'd0);
        reset_ni = 1'b1;

        // Idle frames: nothing lit, frame_done every 16 cycles.
        for (int i = 0; i < 3; i++) begin
            wait_fd("idle", 2'b00, n);
            check("idle period", 32'(n), 32'd16);
            check("idle anodes", 32'(dif.anodes), 32'hFF);
            check("idle grant", 32'(dif.grant), 32'd0);
            repeat (7) @(negedge clock_i);
            check("idle anodes mid", 32'(dif.anodes), 32'hFF);
            wait_fd("idle tail", 2'b00, n);
        end

        // Contention from IDLE: 01,01,10,10,01, switching only at frame boundaries.
        dif.req   = 2'b11;
        dif.data0 = 32'h1111_1111;
        dif.data1 = 32'h2222_2222;
        prev = 2'b00;
        for (int i = 0; i < 5; i++) begin
            wait_fd("rotate", prev, n);
            check("rotate period", 32'(n), 32'd16);
            check("rotate grant", 32'(dif.grant), 32'(exp_g[i]));
            check("rotate digit0", 32'(dif.digit_value), 32'(exp_d0[i]));
            check("rotate anodes", 32'(dif.anodes), 32'hFE);
            prev = exp_g[i];
        end

        // Fresh owner 0 releases mid-frame: switch at frame end despite zero hold.
        repeat (5) @(negedge clock_i);
        dif.req = 2'b10;
        @(negedge clock_i);
        check("release grant held", 32'(dif.grant), 32'b01);
        wait_fd("release", 2'b01, n);
        check("release grant", 32'(dif.grant), 32'b10);

        // Owner 1 releases while 0 requests; full digit scan of 12345678.
        dif.req   = 2'b01;
        dif.data0 = 32'h1234_5678;
        wait_fd("own0", 2'b10, n);
        check("own0 grant", 32'(dif.grant), 32'b01);
        check_frame("scan", an_dig, v_dig, 4, 32'h0000_00A5);

        // Leading-zero blanking on the word loaded at this boundary.
        check("lz grant", 32'(dif.grant), 32'b01);
        dif.lz_blank = 1'b1;
        check_frame("lz", an_lz, v_lz, -1, 32'd0);

        // Zero word: only digit 0 lit, showing 0 (loaded one frame later).
        dif.data0 = 32'd0;
        repeat (16) @(negedge clock_i);
        check("zero boundary", 32'(dif.frame_done), 32'd1);
        check_frame("zero", an_zero, v_zero, -1, 32'd0);

        // Asynchronous reset mid-slot blanks without a clock edge.
        check("pre-reset anodes", 32'(dif.anodes), 32'hFE);
        check("pre-reset grant", 32'(dif.grant), 32'b01);
        #2;
        reset_ni = 1'b0;
        #1;
        check("async reset anodes", 32'(dif.anodes), 32'hFF);
        check("async reset grant", 32'(dif.grant), 32'd0);
        check("async reset value", 32'(dif.digit_value), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
